zilla_iter_divider: RTL and testbench

//  Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU), one quotient bit per cycle.

---
 rtl/zilla_iter_divider_pkg.sv | 20 ++
 rtl/zilla_iter_divider_if.sv | 27 ++
 rtl/zilla_iter_divider_step.sv | 18 +
 rtl/zilla_iter_divider.sv | 144 ++++++++++++++
 tb/tb_zilla_iter_divider.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/zilla_iter_divider_pkg.sv
// Shared definitions for the iterative RV32M divider: op encodings, FSM states and counter width.
package zilla_iter_divider_pkg;

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } div_state_e;

endpackage

// File: rtl/zilla_iter_divider_if.sv
// Request/response bundle between EX issue logic and the iterative divider.
interface zilla_iter_divider_if #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned GPR_ADDR_WIDTH = 5
);
  logic                      div_start_i;
  logic [1:0]                div_op_i;
  logic [XLEN-1:0]           dividend_i;
  logic [XLEN-1:0]           divisor_i;
  logic [GPR_ADDR_WIDTH-1:0] rd_i;
  logic [XLEN-1:0]           result_o;
  logic [GPR_ADDR_WIDTH-1:0] rd_o;
  logic                      div_valid_o;
  logic                      rem_valid_o;
  logic                      div_busy_o;
  logic                      rem_busy_o;

  modport master (
    output div_start_i, div_op_i, dividend_i, divisor_i, rd_i,
    input  result_o, rd_o, div_valid_o, rem_valid_o, div_busy_o, rem_busy_o
  );

  modport slave (
    input  div_start_i, div_op_i, dividend_i, divisor_i, rd_i,
    output result_o, rd_o, div_valid_o, rem_valid_o, div_busy_o, rem_busy_o
  );
endinterface

// File: rtl/zilla_iter_divider_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module zilla_iter_divider_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic            dvd_msb_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_bit_o
);
  logic [XLEN+1:0] trial;

  always_comb begin
    trial   = {rem_i, dvd_msb_i};
    q_bit_o = (trial >= {2'b00, dvs_i});
    rem_o   = q_bit_o ? (XLEN+1)'(trial - {2'b00, dvs_i}) : (XLEN+1)'(trial);
  end
endmodule

// File: rtl/zilla_iter_divider.sv
// Iterative DIV/DIVU/REM/REMU unit, one quotient bit per cycle on unsigned magnitudes.
// Build option: ZILLA_DIV_EARLY_OUT_EN lets trivial operands skip the iteration.
module zilla_iter_divider
  import zilla_iter_divider_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned GPR_ADDR_WIDTH = 5
) (
  input logic                 zilla_div_clk,
  input logic                 zilla_div_rst,
  input logic                 wdt_reset_i,
  zilla_iter_divider_if.slave div_if
);
  div_state_e                state_q, state_d;
  div_op_e                   op_in;
  logic [CNT_W-1:0]          cnt_q;
  logic [XLEN-1:0]           dq_q, dvs_q, result_q;
  logic [XLEN:0]             rem_q, step_rem;
  logic                      step_q, is_rem_q, q_neg_q, r_neg_q;
  logic [GPR_ADDR_WIDTH-1:0] rd_q;
  logic                      signed_op, is_rem_in, dvd_neg, dvs_neg, early_out;
  logic [XLEN-1:0]           abs_dvd, abs_dvs;
`ifdef ZILLA_DIV_EARLY_OUT_EN
  logic                      dvs_zero, ovf, small;
`endif

  always_comb begin
    op_in     = div_op_e'(div_if.div_op_i);
    signed_op = (op_in == OP_DIV) || (op_in == OP_REM);
    is_rem_in = (op_in == OP_REM) || (op_in == OP_REMU);
    dvd_neg   = signed_op & div_if.dividend_i[XLEN-1];
    dvs_neg   = signed_op & div_if.divisor_i[XLEN-1];
    abs_dvd   = dvd_neg ? -div_if.dividend_i : div_if.dividend_i;
    abs_dvs   = dvs_neg ? -div_if.divisor_i : div_if.divisor_i;
`ifdef ZILLA_DIV_EARLY_OUT_EN
    dvs_zero  = (div_if.divisor_i == '0);
    ovf       = signed_op && (div_if.dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (div_if.divisor_i == '1);
    small     = (abs_dvd < abs_dvs);
    early_out = dvs_zero || ovf || small;
`else
    early_out = 1'b0;
`endif
  end

  zilla_iter_divider_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dq_q[XLEN-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  always_ff @(posedge zilla_div_clk or posedge zilla_div_rst) begin
    if (zilla_div_rst)    state_q <= ST_IDLE;
    else if (wdt_reset_i) state_q <= ST_IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    div_if.div_busy_o  = 1'b0;
    div_if.rem_busy_o  = 1'b0;
    div_if.div_valid_o = 1'b0;
    div_if.rem_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: if (div_if.div_start_i) state_d = early_out ? ST_FIX : ST_CALC;
      ST_CALC: begin
        div_if.div_busy_o = ~is_rem_q;
        div_if.rem_busy_o = is_rem_q;
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        div_if.div_busy_o = ~is_rem_q;
        div_if.rem_busy_o = is_rem_q;
        state_d           = ST_DONE;
      end
      ST_DONE: begin
        div_if.div_valid_o = ~is_rem_q;
        div_if.rem_valid_o = is_rem_q;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // dq_q holds the dividend magnitude and fills with quotient bits as it shifts out.
  always_ff @(posedge zilla_div_clk or posedge zilla_div_rst) begin
    if (zilla_div_rst) begin
      cnt_q    <= '0;
      dq_q     <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else if (wdt_reset_i) begin
      cnt_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      is_rem_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (div_if.div_start_i) begin
          is_rem_q <= is_rem_in;
          rd_q     <= div_if.rd_i;
          dvs_q    <= abs_dvs;
          // zero divisor keeps the quotient positive so it stays all-ones
          q_neg_q  <= (dvd_neg ^ dvs_neg) && (div_if.divisor_i != '0);
          r_neg_q  <= dvd_neg;
          cnt_q    <= '0;
          dq_q     <= abs_dvd;
          rem_q    <= '0;
`ifdef ZILLA_DIV_EARLY_OUT_EN
          if (dvs_zero) begin
            dq_q  <= '1;
            rem_q <= {1'b0, abs_dvd};
          end else if (ovf) begin
            dq_q  <= abs_dvd;
            rem_q <= '0;
          end else if (small) begin
            dq_q  <= '0;
            rem_q <= {1'b0, abs_dvd};
          end
`endif
        end
        ST_CALC: begin
          dq_q  <= {dq_q[XLEN-2:0], step_q};
          rem_q <= step_rem;
          cnt_q <= (cnt_q == CNT_W'(XLEN - 1)) ? '0 : cnt_q + 1'b1;
        end
        ST_FIX: begin
          if (is_rem_q) result_q <= XLEN'(r_neg_q ? -rem_q : rem_q);
          else          result_q <= q_neg_q ? -dq_q : dq_q;
        end
        default: ;
      endcase
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.rd_o     = rd_q;
endmodule

// File: tb/tb_zilla_iter_divider.sv
// Randomised self-checking bench for zilla_iter_divider against an arithmetic reference model.
module tb_zilla_iter_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wdt = 1'b0;
  int   checks = 0;
  int   errors = 0;

  zilla_iter_divider_if #(.XLEN(32), .GPR_ADDR_WIDTH(5)) dif ();

  zilla_iter_divider #(.XLEN(32), .GPR_ADDR_WIDTH(5)) dut (
    .zilla_div_clk (clk),
    .zilla_div_rst (rst),
    .wdt_reset_i   (wdt),
    .div_if        (dif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef ZILLA_DIV_EARLY_OUT_EN
    logic [31:0] ma, mb;
    logic        sg;
    sg = ~op[0];
    ma = (sg && a[31]) ? -a : a;
    mb = (sg && b[31]) ? -b : b;
    if (b == 32'd0 || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || ma < mb) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Launches one op from an IDLE cycle and observes it up to the valid pulse plus one cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       output int lat, output logic [31:0] res, output logic [4:0] rdo, output logic kind_ok,
                       output int dbusy, output int rbusy, output int overlap, output logic vafter);
    lat = -1; res = '0; rdo = '0; kind_ok = 1'b0; dbusy = 0; rbusy = 0; overlap = 0;
    dif.div_start_i = 1'b1; dif.div_op_i = op; dif.dividend_i = a; dif.divisor_i = b; dif.rd_i = rd;
    @(posedge clk); #1;
    dif.div_start_i = 1'b0; dif.dividend_i = $urandom; dif.divisor_i = $urandom; dif.rd_i = 5'($urandom);
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      if (((dif.div_busy_o | dif.rem_busy_o) & (dif.div_valid_o | dif.rem_valid_o)) ||
          (dif.div_busy_o & dif.rem_busy_o) || (dif.div_valid_o & dif.rem_valid_o)) overlap++;
      dbusy += int'(dif.div_busy_o);
      rbusy += int'(dif.rem_busy_o);
      if (dif.div_valid_o | dif.rem_valid_o) begin
        lat = k; res = dif.result_o; rdo = dif.rd_o;
        kind_ok = op[1] ? (dif.rem_valid_o & ~dif.div_valid_o) : (dif.div_valid_o & ~dif.rem_valid_o);
      end
      if (lat < 0) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    vafter = dif.div_valid_o | dif.rem_valid_o;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({dif.div_busy_o, dif.rem_busy_o, dif.div_valid_o, dif.rem_valid_o} !== 4'b0) begin
      errors++; $display("FAIL reset_flags_async got %b want 0000",
        {dif.div_busy_o, dif.rem_busy_o, dif.div_valid_o, dif.rem_valid_o});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({dif.result_o, dif.rd_o} !== 37'd0) begin
      errors++; $display("FAIL reset_data result=%h rd=%0d want 0/0", dif.result_o, dif.rd_o);
    end
    checks++;
    if ({dif.div_busy_o, dif.rem_busy_o, dif.div_valid_o, dif.rem_valid_o} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000",
        {dif.div_busy_o, dif.rem_busy_o, dif.div_valid_o, dif.rem_valid_o});
    end
  endtask

  task automatic test_ops(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want);
    int lat, db, rb, ov; logic [31:0] res; logic [4:0] rd, rdo; logic kind, vaft; int el;
    rd = 5'($urandom);
    el = exp_lat(op, a, b);
    do_op(op, a, b, rd, lat, res, rdo, kind, db, rb, ov, vaft);
    checks++; if (lat !== el) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, el); end
    checks++; if (res !== want) begin errors++; $display("FAIL %s_result got %h want %h (op %0d a %h b %h)", name, res, want, op, a, b); end
    checks++; if (rdo !== rd) begin errors++; $display("FAIL %s_rd got %0d want %0d", name, rdo, rd); end
    checks++; if (kind !== 1'b1) begin errors++; $display("FAIL %s_valid_kind got %b want 1", name, kind); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL %s_overlap got %0d want 0", name, ov); end
    checks++; if (db !== (op[1] ? 0 : el - 1)) begin errors++; $display("FAIL %s_div_busy_cycles got %0d want %0d", name, db, op[1] ? 0 : el - 1); end
    checks++; if (rb !== (op[1] ? el - 1 : 0)) begin errors++; $display("FAIL %s_rem_busy_cycles got %0d want %0d", name, rb, op[1] ? el - 1 : 0); end
    checks++; if (vaft !== 1'b0) begin errors++; $display("FAIL %s_valid_width got %b want 0", name, vaft); end
  endtask

  task automatic test_directed();
    test_ops("divu_100_7",  2'b01, 32'd100,         32'd7,           32'd14);
    test_ops("rem_m7_2",    2'b10, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF);
    test_ops("div_m7_2",    2'b00, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD);
    test_ops("div_5_0",     2'b00, 32'd5,           32'd0,           32'hFFFF_FFFF);
    test_ops("remu_5_0",    2'b11, 32'd5,           32'd0,           32'd5);
    test_ops("div_ovf",     2'b00, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000);
    test_ops("rem_ovf",     2'b10, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0);
    test_ops("divu_3_9",    2'b01, 32'd3,           32'd9,           32'd0);
    test_ops("rem_m5_0",    2'b10, 32'hFFFF_FFFB,   32'd0,           32'hFFFF_FFFB);
  endtask

  task automatic test_random();
    logic [1:0] op; logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      test_ops("random", op, a, b, ref_result(op, a, b));
    end
  endtask

  task automatic test_ignore_start();
    int lat; logic [31:0] res; logic [4:0] rdo; logic kind;
    lat = -1; res = '0; rdo = '0; kind = 1'b0;
    dif.div_start_i = 1'b1; dif.div_op_i = 2'b00; dif.dividend_i = 32'd1000003; dif.divisor_i = 32'd7; dif.rd_i = 5'd9;
    @(posedge clk); #1;
    dif.div_start_i = 1'b0;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      dif.div_start_i = (k == 10);
      if (k == 10) begin dif.div_op_i = 2'b11; dif.dividend_i = $urandom; dif.divisor_i = 32'd3; dif.rd_i = 5'd22; end
      if (dif.div_valid_o | dif.rem_valid_o) begin
        lat = k; res = dif.result_o; rdo = dif.rd_o; kind = dif.div_valid_o & ~dif.rem_valid_o;
      end
      if (lat < 0) begin @(posedge clk); #1; end
    end
    dif.div_start_i = 1'b0;
    checks++; if (lat !== 34) begin errors++; $display("FAIL ignore_latency got %0d want 34", lat); end
    checks++; if (res !== 32'd142857) begin errors++; $display("FAIL ignore_result got %h want %h", res, 32'd142857); end
    checks++; if (rdo !== 5'd9) begin errors++; $display("FAIL ignore_rd got %0d want 9", rdo); end
    checks++; if (kind !== 1'b1) begin errors++; $display("FAIL ignore_valid_kind got %b want 1", kind); end
    @(posedge clk); #1;
  endtask

  task automatic test_wdt();
    logic seen; int lat, db, rb, ov; logic [31:0] res; logic [4:0] rdo; logic kind, vaft;
    seen = 1'b0;
    dif.div_start_i = 1'b1; dif.div_op_i = 2'b01; dif.dividend_i = 32'hFFFF_0000; dif.divisor_i = 32'd3; dif.rd_i = 5'd17;
    @(posedge clk); #1;
    dif.div_start_i = 1'b0;
    for (int k = 1; k < 15; k++) begin
      seen |= dif.div_valid_o | dif.rem_valid_o;
      @(posedge clk); #1;
    end
    wdt = 1'b1;
    @(posedge clk); #1;
    wdt = 1'b0;
    checks++; if ({dif.div_busy_o, dif.rem_busy_o} !== 2'b00) begin errors++; $display("FAIL wdt_busy got %b want 00", {dif.div_busy_o, dif.rem_busy_o}); end
    checks++; if ({dif.result_o, dif.rd_o} !== 37'd0) begin errors++; $display("FAIL wdt_outputs result=%h rd=%0d want 0/0", dif.result_o, dif.rd_o); end
    @(posedge clk); #1;
    seen |= dif.div_valid_o | dif.rem_valid_o;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL wdt_no_valid got %b want 0", seen); end
    do_op(2'b00, 32'hFFFF_FF00, 32'd16, 5'd3, lat, res, rdo, kind, db, rb, ov, vaft);
    checks++; if (lat !== 34) begin errors++; $display("FAIL wdt_restart_latency got %0d want 34", lat); end
    checks++; if (res !== 32'hFFFF_FFF0) begin errors++; $display("FAIL wdt_restart_result got %h want fffffff0", res); end
  endtask

  task automatic test_async_reset();
    dif.div_start_i = 1'b1; dif.div_op_i = 2'b10; dif.dividend_i = 32'd123456; dif.divisor_i = 32'd10; dif.rd_i = 5'd30;
    @(posedge clk); #1;
    dif.div_start_i = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dif.result_o, dif.rd_o, dif.div_busy_o, dif.rem_busy_o, dif.div_valid_o, dif.rem_valid_o} !== 41'd0) begin
      errors++; $display("FAIL async_reset result=%h rd=%0d flags=%b want all 0", dif.result_o, dif.rd_o,
        {dif.div_busy_o, dif.rem_busy_o, dif.div_valid_o, dif.rem_valid_o});
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({dif.div_busy_o, dif.rem_busy_o, dif.div_valid_o, dif.rem_valid_o} !== 4'b0) begin
      errors++; $display("FAIL async_reset_idle flags=%b want 0000", {dif.div_busy_o, dif.rem_busy_o, dif.div_valid_o, dif.rem_valid_o});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom_range(1, 1000);
      test_ops("back_to_back", 2'(i), a, b, ref_result(2'(i), a, b));
    end
  endtask

  initial begin
    dif.div_start_i = 1'b0; dif.div_op_i = 2'b00; dif.dividend_i = '0; dif.divisor_i = '0; dif.rd_i = '0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_wdt();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
